// File: rtl/if_fetch_queue.sv
// Fetch-side instruction queue: buffers {PC, instruction} pairs from a variable-latency
// instruction memory and presents the oldest entry to decode, gating the PC advance.
module if_fetch_queue #(
  parameter int          DEPTH = 2,
  parameter int          AW    = 1,
  parameter logic [31:0] NOP   = 32'h0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   instr_i,
  input  logic          imem_ready_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          pc_write_o,
  output logic          id_valid_o,
  output logic [31:0]   id_pc_o,
  output logic [31:0]   id_pc_plus4_o,
  output logic [31:0]   id_instr_o,
  output logic [AW:0]   count_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  entry_t        head;

  assign id_valid_o = (count_q != '0);
  assign pop        = id_valid_o & ~stall_i & ~flush_i;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push       = imem_ready_i & ~flush_i & ((count_q < FULL_COUNT) | pop);
  assign pc_write_o = rst_i & (push | flush_i);

  // Pointers are AW bits wide, so increment wraps modulo DEPTH for free.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      // NOTE: entry storage is reset too, so the head reads {0, NOP} straight out of reset;
      // this costs a reset net on every storage flop, which plain FIFO RAM would normally skip.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: 32'h0, instr: NOP};
      end
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // NOTE: non-blocking updates here let push and pop both read the pre-edge count.
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head          = mem[rd_ptr];
  assign id_pc_o       = head.pc;
  assign id_pc_plus4_o = head.pc + 32'd4;
  assign id_instr_o    = id_valid_o ? head.instr : NOP;
  assign count_o       = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed fetch vectors push expected entries,
// a monitor compares every entry decode accepts against the scoreboard.
module tb_if_fetch_queue;

  localparam logic [31:0] NOP = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        imem_ready_i;
  logic        stall_i;
  logic        flush_i;
  logic        pc_write_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic [31:0] id_instr_o;
  logic [1:0]  count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  if_fetch_queue #(.DEPTH(2), .AW(1), .NOP(NOP)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .imem_ready_i  (imem_ready_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .pc_write_o    (pc_write_o),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_pc_plus4_o (id_pc_plus4_o),
    .id_instr_o    (id_instr_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One fetch cycle: drive inputs after the rising edge, check combinational PC enable and
  // occupancy mid-cycle, and record the entry when this fetch is expected to be enqueued.
  task automatic cyc(input logic [31:0] pc, input logic [31:0] ins, input logic rdy,
                     input logic st, input logic fl, input logic exp_push,
                     input int exp_cnt, input string nm);
    pc_i = pc; instr_i = ins; imem_ready_i = rdy; stall_i = st; flush_i = fl;
    if (exp_push) sb.push_back('{pc: pc, instr: ins});
    @(negedge clk_i);
    check({nm, " pc_write"}, {31'b0, pc_write_o}, {31'b0, exp_push | fl});
    check({nm, " count"}, {30'b0, count_o}, exp_cnt);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every entry decode accepts must match the oldest expected fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i && id_valid_o && !stall_i && !flush_i) begin
        if (sb.size() == 0) begin
          check("unexpected pop", id_pc_o, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("head pc", id_pc_o, e.pc);
          check("head instr", id_instr_o, e.instr);
          check("head pc+4", id_pc_plus4_o, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b0; pc_i = 32'h100; instr_i = 32'hDEAD_BEEF;
    imem_ready_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;

    // T1 reset for two edges with memory ready
    @(negedge clk_i);
    check("rst pc_write", {31'b0, pc_write_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst pc_write 2", {31'b0, pc_write_o}, 32'd0);
    check("rst valid", {31'b0, id_valid_o}, 32'd0);
    check("rst instr", id_instr_o, NOP);
    check("rst pc", id_pc_o, 32'd0);
    check("rst pc+4", id_pc_plus4_o, 32'd4);
    check("rst count", {30'b0, count_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // T2 streaming
    cyc(32'h0, 32'hAAAA_0001, 1, 0, 0, 1, 0, "t2 c0");
    check("t2 latency valid", {31'b0, id_valid_o}, 32'd1);
    cyc(32'h4, 32'hBBBB_0002, 1, 0, 0, 1, 1, "t2 c1");
    cyc(32'h8, 32'hCCCC_0003, 1, 0, 0, 1, 1, "t2 c2");

    // T3 stall fill: C held, D accepted, then PC holds on E
    cyc(32'hC,  32'hDDDD_0004, 1, 1, 0, 1, 1, "t3 c0");
    cyc(32'h10, 32'hEEEE_0005, 1, 1, 0, 0, 2, "t3 c1");
    cyc(32'h10, 32'hEEEE_0005, 1, 1, 0, 0, 2, "t3 c2");
    cyc(32'h10, 32'hEEEE_0005, 1, 1, 0, 0, 2, "t3 c3");

    // T4 full with simultaneous push/pop, pointers wrap
    cyc(32'h10, 32'hEEEE_0005, 1, 0, 0, 1, 2, "t4 c0");
    cyc(32'h14, 32'hFFFF_0006, 1, 0, 0, 1, 2, "t4 c1");

    // T5 flush while full and stalled
    cyc(32'h18, 32'h1111_0007, 1, 1, 1, 0, 2, "t5 flush");
    sb.delete();
    check("t5 count", {30'b0, count_o}, 32'd0);
    check("t5 valid", {31'b0, id_valid_o}, 32'd0);
    check("t5 instr", id_instr_o, NOP);

    // T6 refill, then memory wait drains the queue
    cyc(32'h40, 32'h2222_0008, 1, 1, 0, 1, 0, "t6 fill0");
    cyc(32'h44, 32'h3333_0009, 1, 1, 0, 1, 1, "t6 fill1");
    cyc(32'h48, 32'h4444_000A, 0, 0, 0, 0, 2, "t6 wait0");
    cyc(32'h48, 32'h4444_000A, 0, 0, 0, 0, 1, "t6 wait1");
    cyc(32'h48, 32'h4444_000A, 0, 0, 0, 0, 0, "t6 wait2");
    check("t6 valid", {31'b0, id_valid_o}, 32'd0);
    check("t6 instr", id_instr_o, NOP);

    repeat (2) @(posedge clk_i);
    check("scoreboard drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
